// File: rtl/instenc_loader.sv
// instenc_loader: packs SRM instruction fields into 16-bit words and writes them to consecutive imem addresses.
// Latency: a handshake at edge k gives ENC in cycle k+1, mem_write in cycle k+2 and in_ready again in cycle k+3.
// Backpressure: in_ready is high only in ACCEPT; HALT, an illegal field or a full memory stops loading until start.
// Ports: clk/reset (sync, active-high); start restarts at BASE_ADDR; in_valid/in_ready carry one field bundle
//   (opcode, op, rn, rd, rm, shift, imm); mem_addr/mem_wdata/mem_write drive the imem write port;
//   instr_count counts words since start; done/err/err_code report how loading stopped and are held.
module instenc_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [15:0]       imm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_write,
  output logic [ADDR_W:0]   instr_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        ERR_OPC  = 2'b01;
  localparam logic [1:0]        ERR_IMM  = 2'b10;
  localparam logic [1:0]        ERR_FULL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_ENC, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        opc_q, rn_q, rd_q, rm_q;
  logic [1:0]        op_q, sh_q;
  logic [15:0]       imm_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        ecode_q, ecode_d;
  logic              capture;

  logic [15:0] enc_word;
  logic        enc_illegal;
  logic        enc_range_bad;
  logic        imm8_ok;
  logic        imm5_ok;

  // A 16-bit value fits an N-bit signed field iff every bit from N-1 upward equals the sign bit.
  assign imm8_ok = (&imm_q[15:7]) | ~(|imm_q[15:7]);
  assign imm5_ok = (&imm_q[15:4]) | ~(|imm_q[15:4]);

  // Encoder: works on the registered fields only, unused fields are encoded as zero.
  always_comb begin
    enc_word      = 16'h0000;
    enc_illegal   = 1'b0;
    enc_range_bad = 1'b0;
    case (opc_q)
      3'b110: begin
        case (op_q)
          2'b10: begin
            enc_word      = {3'b110, 2'b10, rn_q, imm_q[7:0]};
            enc_range_bad = ~imm8_ok;
          end
          2'b00:   enc_word = {3'b110, 2'b00, 3'b000, rd_q, sh_q, rm_q};
          default: enc_illegal = 1'b1;
        endcase
      end
      3'b101: begin
        // CMP has no destination and MVN has no first source.
        enc_word = {3'b101, op_q,
                    (op_q == 2'b11) ? 3'b000 : rn_q,
                    (op_q == 2'b01) ? 3'b000 : rd_q,
                    sh_q, rm_q};
      end
      3'b011, 3'b100: begin
        if (op_q == 2'b00) begin
          enc_word      = {opc_q, 2'b00, rn_q, rd_q, imm_q[4:0]};
          enc_range_bad = ~imm5_ok;
        end else begin
          enc_illegal = 1'b1;
        end
      end
      3'b111:  enc_word = 16'hE000;
      default: enc_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ecode_d = ecode_q;
    capture = 1'b0;
    if (start) begin
      // start wins everywhere; in WRITE the strobe still fires but the increments are dropped.
      state_d = S_ACCEPT;
      addr_d  = BASE;
      cnt_d   = '0;
      ecode_d = 2'b00;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (in_valid) begin
            capture = 1'b1;
            state_d = S_ENC;
          end
        end
        S_ENC: begin
          if (enc_illegal) begin
            state_d = S_ERROR;
            ecode_d = ERR_OPC;
          end else if (enc_range_bad) begin
            state_d = S_ERROR;
            ecode_d = ERR_IMM;
          end else begin
            wdata_d = enc_word;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // Only HALT carries opcode 111, so the written word itself tells us.
          if (wdata_q[15:13] == 3'b111) begin
            state_d = S_DONE;
          end else if (&addr_q) begin
            state_d = S_ERROR;
            ecode_d = ERR_FULL;
          end else begin
            state_d = S_ACCEPT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      wdata_q <= 16'h0000;
      cnt_q   <= '0;
      ecode_q <= 2'b00;
      opc_q   <= 3'b000;
      op_q    <= 2'b00;
      rn_q    <= 3'b000;
      rd_q    <= 3'b000;
      rm_q    <= 3'b000;
      sh_q    <= 2'b00;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ecode_q <= ecode_d;
      if (capture) begin
        opc_q <= opcode;
        op_q  <= op;
        rn_q  <= rn;
        rd_q  <= rd;
        rm_q  <= rm;
        sh_q  <= shift;
        imm_q <= imm;
      end
    end
  end

  assign in_ready    = (state_q == S_ACCEPT);
  assign mem_write   = (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign err         = (state_q == S_ERROR);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign instr_count = cnt_q;
  assign err_code    = ecode_q;

endmodule

// File: tb/tb_instenc_loader.sv
module tb_instenc_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, shift;
  logic [15:0] imm;

  logic        in_ready, mem_write, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  instr_count;
  logic [1:0]  err_code;

  logic        in_ready2, mem_write2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [15:0] mem_wdata2;
  logic [2:0]  instr_count2;
  logic [1:0]  err_code2;

  instenc_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .instr_count(instr_count), .done(done), .err(err), .err_code(err_code));

  instenc_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_write(mem_write2),
    .instr_count(instr_count2), .done(done2), .err(err2), .err_code(err_code2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int q2[$];
  int m_addr = 0;
  int m_cnt  = 0;
  bit m_live = 1'b0;

  always @(negedge clk) begin
    if (mem_write === 1'b1) n_wr++;
    if (mem_write2 === 1'b1) q2.push_back(int'(mem_addr2));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: builds the word from field weights and checks ranges as integers.
  function automatic void ref_enc(input logic [2:0] o, input logic [1:0] p, input logic [2:0] a,
                                  input logic [2:0] b, input logic [2:0] c, input logic [1:0] s,
                                  input logic [15:0] im, output logic [15:0] w, output logic [1:0] code);
    int v, wi, rnv, rdv;
    v    = int'($signed(im));
    wi   = 0;
    code = 2'd0;
    if (o == 3'd7) begin
      wi = 7 * 8192;
    end else if (o == 3'd6 && p == 2'd2) begin
      if (v < -128 || v > 127) code = 2'd2;
      else wi = 6 * 8192 + 2 * 2048 + int'(a) * 256 + (v & 255);
    end else if (o == 3'd6 && p == 2'd0) begin
      wi = 6 * 8192 + int'(b) * 32 + int'(s) * 8 + int'(c);
    end else if (o == 3'd5) begin
      rnv = (p == 2'd3) ? 0 : int'(a);
      rdv = (p == 2'd1) ? 0 : int'(b);
      wi  = 5 * 8192 + int'(p) * 2048 + rnv * 256 + rdv * 32 + int'(s) * 8 + int'(c);
    end else if ((o == 3'd3 || o == 3'd4) && p == 2'd0) begin
      if (v < -16 || v > 15) code = 2'd2;
      else wi = int'(o) * 8192 + int'(a) * 256 + int'(b) * 32 + (v & 31);
    end else begin
      code = 2'd1;
    end
    w = (code == 2'd0) ? 16'(wi) : 16'h0000;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_addr", mem_addr, 0);
    chk("start_count", instr_count, 0);
    chk("start_err", {err, err_code}, 0);
    chk("start_done", done, 0);
    m_addr = 0;
    m_cnt  = 0;
    m_live = 1'b1;
  endtask

  // Returns one cycle after the handshake edge (ENC cycle).
  task automatic send(input logic [2:0] o, input logic [1:0] p, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input logic [1:0] s, input logic [15:0] im, output bit ok);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", in_ready, 1);
    ok = (in_ready === 1'b1);
    if (ok) begin
      opcode = o; op = p; rn = a; rd = b; rm = c; shift = s; imm = im;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic load(input logic [2:0] o, input logic [1:0] p, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input logic [1:0] s, input logic [15:0] im,
                      input logic [15:0] ew, input logic [1:0] ec);
    bit ok;
    int wr0;
    send(o, p, a, b, c, s, im, ok);
    if (!ok) return;
    chk("enc_ready_low", in_ready, 0);
    wr0 = n_wr;
    @(posedge clk); #1;
    if (ec == 2'd0) begin
      chk("wr_strobe", mem_write, 1);
      chk("wr_addr", mem_addr, m_addr);
      chk("wr_data", mem_wdata, ew);
      @(posedge clk); #1;
      m_cnt++;
      chk("wr_strobe_end", mem_write, 0);
      chk("count", instr_count, m_cnt);
      chk("addr_inc", mem_addr, (m_addr + 1) % 256);
      if (o == 3'd7) begin
        chk("halt_done", {done, err, in_ready}, 3'b100);
        m_live = 1'b0;
      end else if (m_addr == 255) begin
        chk("full_err", {err, err_code, in_ready}, 4'b1110);
        m_live = 1'b0;
      end else begin
        chk("ready_back", {in_ready, done, err}, 3'b100);
      end
      m_addr = (m_addr + 1) % 256;
    end else begin
      chk("err_no_write", mem_write, 0);
      chk("err_flag", {err, in_ready, done}, 3'b100);
      chk("err_code", err_code, ec);
      @(posedge clk); #1;
      chk("err_held", {err, err_code, in_ready}, {1'b1, ec, 1'b0});
      chk("err_write_count", n_wr, wr0);
      m_live = 1'b0;
    end
  endtask

  typedef struct {
    bit          restart;
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [15:0] imm;
    logic [15:0] ew;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl[18];

  initial begin
    bit ok;
    int wr0, kind, ik, v;
    logic [2:0]  ro, ra, rb, rc;
    logic [1:0]  rp, rs;
    logic [15:0] ri, ew;
    logic [1:0]  ec;

    tbl[0]  = '{1'b1, 3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0007, 16'hD007, 2'd0};
    tbl[1]  = '{1'b0, 3'd5, 2'd0, 3'd1, 3'd2, 3'd0, 2'd1, 16'h0000, 16'hA148, 2'd0};
    tbl[2]  = '{1'b0, 3'd5, 2'd1, 3'd1, 3'd5, 3'd3, 2'd2, 16'h0000, 16'hA913, 2'd0};
    tbl[3]  = '{1'b0, 3'd5, 2'd3, 3'd6, 3'd2, 3'd7, 2'd0, 16'h0000, 16'hB847, 2'd0};
    tbl[4]  = '{1'b0, 3'd5, 2'd2, 3'd3, 3'd4, 3'd5, 2'd3, 16'h0000, 16'hB39D, 2'd0};
    tbl[5]  = '{1'b0, 3'd6, 2'd0, 3'd7, 3'd1, 3'd2, 2'd1, 16'h1234, 16'hC02A, 2'd0};
    tbl[6]  = '{1'b0, 3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFF80, 16'hD080, 2'd0};
    tbl[7]  = '{1'b0, 3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFF7F, 16'h0000, 2'd2};
    tbl[8]  = '{1'b1, 3'd3, 2'd0, 3'd4, 3'd3, 3'd0, 2'd0, 16'hFFF0, 16'h6470, 2'd0};
    tbl[9]  = '{1'b0, 3'd4, 2'd0, 3'd2, 3'd1, 3'd0, 2'd0, 16'h000F, 16'h822F, 2'd0};
    tbl[10] = '{1'b0, 3'd6, 2'd2, 3'd5, 3'd0, 3'd0, 2'd0, 16'h007F, 16'hD57F, 2'd0};
    tbl[11] = '{1'b0, 3'd3, 2'd0, 3'd4, 3'd3, 3'd0, 2'd0, 16'h0010, 16'h0000, 2'd2};
    tbl[12] = '{1'b1, 3'd0, 2'd0, 3'd1, 3'd1, 3'd1, 2'd1, 16'h0005, 16'h0000, 2'd1};
    tbl[13] = '{1'b1, 3'd6, 2'd1, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 16'h0000, 2'd1};
    tbl[14] = '{1'b1, 3'd3, 2'd1, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 16'h0000, 2'd1};
    tbl[15] = '{1'b1, 3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0100, 16'h0000, 2'd2};
    tbl[16] = '{1'b1, 3'd3, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h8000, 16'h0000, 2'd2};
    tbl[17] = '{1'b1, 3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0080, 16'h0000, 2'd2};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    opcode = 3'd0; op = 2'd0; rn = 3'd0; rd = 3'd0; rm = 3'd0; shift = 2'd0; imm = 16'h0000;

    // Reset values, then IDLE ignores in_valid.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {in_ready, mem_write, done, err, err_code}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", instr_count, 0);
    reset = 1'b0;
    opcode = 3'd6; op = 2'd2; imm = 16'h0001;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("idle_no_write", n_wr, 0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].restart) do_start();
      load(tbl[i].opc, tbl[i].op, tbl[i].rn, tbl[i].rd, tbl[i].rm, tbl[i].sh, tbl[i].imm, tbl[i].ew, tbl[i].ec);
    end

    // Two instructions then HALT; block must then refuse input until start.
    do_start();
    load(3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0007, 16'hD007, 2'd0);
    load(3'd5, 2'd0, 3'd1, 3'd2, 3'd0, 2'd1, 16'h0000, 16'hA148, 2'd0);
    load(3'd7, 2'd3, 3'd5, 3'd5, 3'd5, 2'd3, 16'hFFFF, 16'hE000, 2'd0);
    chk("halt_count", instr_count, 3);
    wr0 = n_wr;
    opcode = 3'd6; op = 2'd2; imm = 16'h0003;
    in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("done_ready_low", {in_ready, done}, 2'b01);
    end
    in_valid = 1'b0;
    chk("done_no_write", n_wr, wr0);
    do_start();

    // start during WRITE: strobe still seen, increments discarded.
    load(3'd6, 2'd2, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0001, 16'hD001, 2'd0);
    send(3'd6, 2'd2, 3'd1, 3'd0, 3'd0, 2'd0, 16'h0002, ok);
    @(posedge clk); #1;
    chk("sw_strobe", {mem_write, mem_addr}, {1'b1, 8'd1});
    chk("sw_data", mem_wdata, 16'hD102);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("sw_restart", {mem_addr, instr_count, in_ready, mem_write}, {8'd0, 9'd0, 1'b1, 1'b0});
    m_addr = 0; m_cnt = 0; m_live = 1'b1;

    // Full memory on the 4-word instance.
    do_start();
    q2.delete();
    for (int i = 0; i < 4; i++) begin
      ref_enc(3'd5, 2'd0, 3'd1, 3'd2, 3'(i), 2'd1, 16'h0000, ew, ec);
      load(3'd5, 2'd0, 3'd1, 3'd2, 3'(i), 2'd1, 16'h0000, ew, ec);
    end
    chk("full_state", {err2, err_code2, in_ready2, done2, mem_write2}, 6'b111000);
    chk("full_count", instr_count2, 4);
    chk("full_addr_wrap", mem_addr2, 0);
    chk("full_last_word", mem_wdata2, 16'hA14B);
    chk("full_writes", q2.size(), 4);
    for (int i = 0; i < 4 && i < q2.size(); i++) chk("full_wr_addr", q2[i], i);

    // Reset during WRITE.
    do_start();
    send(3'd6, 2'd2, 3'd3, 3'd0, 3'd0, 2'd0, 16'h0005, ok);
    @(posedge clk); #1;
    chk("rw_strobe", mem_write, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rw_ctrl", {in_ready, mem_write, done, err, err_code}, 0);
    chk("rw_addr", mem_addr, 0);
    chk("rw_wdata", mem_wdata, 0);
    chk("rw_count", instr_count, 0);
    m_live = 1'b0;

    // Randomised traffic against the reference encoder.
    for (int n = 0; n < 150; n++) begin
      if (!m_live) do_start();
      kind = $urandom_range(0, 9);
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      rc = 3'($urandom_range(0, 7));
      rs = 2'($urandom_range(0, 3));
      rp = 2'($urandom_range(0, 3));
      case (kind)
        0:       begin ro = 3'd6; rp = 2'd2; end
        1:       begin ro = 3'd6; rp = 2'd0; end
        2, 3, 4: ro = 3'd5;
        5:       begin ro = 3'd3; rp = 2'd0; end
        6:       begin ro = 3'd4; rp = 2'd0; end
        7:       ro = 3'd7;
        default: ro = 3'($urandom_range(0, 7));
      endcase
      ik = $urandom_range(0, 3);
      case (ik)
        0:       v = int'($urandom_range(0, 40)) - 20;
        1:       v = int'($urandom_range(0, 280)) - 140;
        2:       v = int'($urandom_range(0, 65535));
        default: begin
          case ($urandom_range(0, 7))
            0: v = -129; 1: v = -128; 2: v = 127; 3: v = 128;
            4: v = -17;  5: v = -16;  6: v = 15;  default: v = 16;
          endcase
        end
      endcase
      ri = 16'(v);
      ref_enc(ro, rp, ra, rb, rc, rs, ri, ew, ec);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      load(ro, rp, ra, rb, rc, rs, ri, ew, ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instenc_loader.md
# instenc_loader

Instruction encoder and program loader for the Simple RISC Machine: the inverse of the instruction decoder. It accepts one instruction's fields (opcode, op, Rn, Rd, Rm, shift, signed immediate) per valid/ready transfer, checks legality, packs them into the 16-bit instruction word, and writes the words to consecutive instruction-memory addresses. It sits between the test or boot sequencer and the instruction RAM write port. Loading stops on HALT, an illegal field, or a full memory.

## Interface
- ADDR_W, 8, instruction-memory address width
- BASE_ADDR, 0, first load address
- clk  in  1  rising-edge clock; the block uses one clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: (re)start loading at BASE_ADDR
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle
- opcode  in  3  instr[15:13]
- op  in  2  instr[12:11]; ALUop for opcode 101
- rn, rd, rm  in  3 each  register numbers
- shift  in  2  sh field, instr[4:3]
- imm  in  16  two's-complement immediate
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  encoded instruction
- mem_write  out  1  write strobe, one cycle per instruction
- instr_count  out  ADDR_W+1  words written since start
- done  out  1  HALT written; held
- err  out  1  load aborted; held
- err_code  out  2  01 illegal opcode/op, 10 immediate out of range, 11 memory full

## Operation
- States: IDLE, ACCEPT, ENC, WRITE, DONE, ERROR.
- Reset forces IDLE. All outputs are 0 except mem_addr, which resets to BASE_ADDR. Reset overrides every other input.
- IDLE: in_ready=0. On start, the block goes to ACCEPT, loads mem_addr=BASE_ADDR, clears count, err, err_code, and done.
- start is honoured in every state with the same effect. If start arrives in WRITE, that cycle's mem_write is still asserted, but the address and count increments are discarded.
- ACCEPT: in_ready=1. When in_valid and in_ready are both high, all fields are captured into registers and the block goes to ENC. Inputs are ignored at all other times.
- ENC checks legality on the registered fields and builds the word:
  - 110/10 MOV Rn,#imm8 → {110,10,rn,imm[7:0]}; imm must lie in [-128,127].
  - 110/00 MOV Rd,Rm,sh → {110,00,000,rd,shift,rm}.
  - 101/00 ADD and 101/10 AND → {101,op,rn,rd,shift,rm}.
  - 101/01 CMP → Rd field forced to 000.
  - 101/11 MVN → Rn field forced to 000.
  - 011/00 LDR and 100/00 STR → {opc,00,rn,rd,imm[4:0]}; imm must lie in [-16,15].
  - 111/any HALT → 16'hE000.
  - Any other opcode/op pair is illegal and produces err_code 01.
  - Fields that a format does not use are ignored and encoded as 0.
  - Range is checked on the full 16-bit signed value, not on truncated bits.
- ENC outcome: a failed check goes to ERROR with the matching err_code. A legal word is registered into mem_wdata and the block goes to WRITE.
- WRITE: mem_write=1 for this cycle only. Next, count increments and mem_addr increments (wrapping at ADDR_W bits). Then:
  - HALT → DONE.
  - Otherwise, if the word was written at address 2^ADDR_W−1 → ERROR with err_code 11.
  - Otherwise → ACCEPT.
- DONE: done=1, in_ready=0. The block waits for start.
- ERROR: err=1, in_ready=0. err_code is held until start or reset. No further writes occur.
- mem_wdata and mem_addr hold their values outside WRITE.

## Timing
- A handshake at edge k leads to ENC in cycle k+1, mem_write high in cycle k+2, and in_ready high again in cycle k+3.
- Throughput is one instruction per 3 cycles.
- mem_write, mem_addr, and mem_wdata are registered-stable during the strobe cycle. Memory samples them at the edge that ends WRITE.
- instr_count updates on the edge that ends WRITE.
- done and err assert in the first cycle of DONE or ERROR.
- An error detected in ENC never produces a mem_write.

## Test plan
- Reset, start, then load MOV R0,#7 (110/10, rn=0, imm=7): mem_write pulses once at addr 0 with wdata 16'hD007; count becomes 1; in_ready returns 3 cycles after the handshake.
- Load ADD R2,R1,R0,LSL#1 (101/00, rn=1, rd=2, rm=0, sh=01) → 16'hA148. Load CMP with rd=5 → Rd field is 000.
- MOV R0,#-128 → 16'hD080. Then MOV imm=-129 → err=1, err_code 10, no mem_write, in_ready stays 0.
- LDR R3,[R4,#-16] (011/00, rn=4, rd=3, imm=-16) → 16'h6470. Then imm=16 → err_code 10. Then opcode 000 → err_code 01.
- Load two instructions then HALT → 16'hE000 at addr 2; done=1; count=3; further in_valid is not accepted. start then restarts at addr 0 with count=0.
- ADDR_W=2, load 4 non-HALT instructions → writes at addrs 0–3, then err_code 11. A separate case asserts reset during WRITE: all outputs return to reset values on the next cycle.
